bram_1rport_1wport_fifo: RTL and testbench

BRAM-backed synchronous FIFO controller that instantiates bram_1rport_1wport as storage and drives both its ports. It hides the BRAM's one-cycle registered read latency behind a prefetching output register, presenting valid/ready enqueue and dequeue interfaces. Used wherever deep queues (fetch buffers, load/store queues, trace buffers) must map to block RAM instead of flops.

---
 rtl/bram_1rport_1wport_fifo_pkg.sv | 26 ++
 rtl/bram_1rport_1wport_fifo_bram.sv | 44 ++++
 rtl/bram_1rport_1wport_fifo.sv | 123 ++++++++++++
 tb/tb_bram_1rport_1wport_fifo.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_1rport_1wport_fifo_pkg.sv
// ---------------------------------------------------------------------------
// bram_1rport_1wport_fifo_pkg
//   Shared defaults and helpers for the BRAM-backed FIFO controller.
//   Contents:
//     FIFO_DEFAULT_DEPTH / FIFO_DEFAULT_WIDTH : default geometry
//     fifo_rd_issue()                         : BRAM read-issue condition
// ---------------------------------------------------------------------------
package bram_1rport_1wport_fifo_pkg;

    localparam int unsigned FIFO_DEFAULT_DEPTH = 32;
    localparam int unsigned FIFO_DEFAULT_WIDTH = 32;

    // A read is launched only when the output slot is (or is about to be) free:
    // either nothing is held or in flight, or the held head is being taken now.
    function automatic logic fifo_rd_issue(
        input logic count_nz,
        input logic flush,
        input logic deq_valid,
        input logic read_inflight,
        input logic deq_ready
    );
        return count_nz & ~flush &
               ((~deq_valid & ~read_inflight) | (deq_valid & deq_ready));
    endfunction

endpackage

// File: rtl/bram_1rport_1wport_fifo_bram.sv
// ---------------------------------------------------------------------------
// bram_1rport_1wport
//   Simple dual-port block RAM: one byte-enabled write port, one read port
//   with a registered output (rdata valid the cycle after ren). Contents are
//   not reset.
//   Ports:
//     CLK       clock
//     wen_byte  per-byte write enables
//     windex    write address
//     wdata     write data
//     ren       read enable
//     rindex    read address
//     rdata     registered read data
// ---------------------------------------------------------------------------
module bram_1rport_1wport #(
    parameter int unsigned OUTER_WIDTH = 32,
    parameter int unsigned INNER_WIDTH = 32
) (
    input  logic                           CLK,
    input  logic [INNER_WIDTH/8-1:0]       wen_byte,
    input  logic [$clog2(OUTER_WIDTH)-1:0] windex,
    input  logic [INNER_WIDTH-1:0]         wdata,
    input  logic                           ren,
    input  logic [$clog2(OUTER_WIDTH)-1:0] rindex,
    output logic [INNER_WIDTH-1:0]         rdata
);

    logic [INNER_WIDTH-1:0] mem_q [OUTER_WIDTH];
    logic [INNER_WIDTH-1:0] rdata_q;

    always_ff @(posedge CLK) begin
        for (int unsigned b = 0; b < INNER_WIDTH / 8; b++) begin
            if (wen_byte[b]) begin
                mem_q[windex][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (ren) begin
            rdata_q <= mem_q[rindex];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bram_1rport_1wport_fifo.sv
// ---------------------------------------------------------------------------
// bram_1rport_1wport_fifo
//   Synchronous FIFO whose storage is a bram_1rport_1wport. The BRAM's
//   one-cycle read latency is hidden behind a prefetching output register,
//   so total capacity is DEPTH (BRAM) + 1 (output register).
//   Ports:
//     CLK        clock
//     nRST       synchronous active-low reset
//     flush      discard all contents and any in-flight read
//     enq_valid  enqueue request          enq_data  enqueue payload
//     enq_ready  enqueue may be accepted
//     deq_valid  deq_data holds the head  deq_data  head payload
//     deq_ready  consumer takes the head
//     occupancy  bram_count + deq_valid + read_inflight
// ---------------------------------------------------------------------------
module bram_1rport_1wport_fifo
    import bram_1rport_1wport_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEFAULT_DEPTH,
    parameter int unsigned WIDTH = FIFO_DEFAULT_WIDTH
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  logic [WIDTH-1:0]           enq_data,
    output logic                       enq_ready,
    output logic                       deq_valid,
    output logic [WIDTH-1:0]           deq_data,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH+2)-1:0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 2);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BE_W  = WIDTH / 8;

    logic [PTR_W-1:0] wptr_q,      wptr_d;
    logic [PTR_W-1:0] rptr_q,      rptr_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             inflight_q,  inflight_d;
    logic             deq_valid_q, deq_valid_d;
    logic [WIDTH-1:0] deq_data_q,  deq_data_d;

    logic             enq_fire;
    logic             deq_fire;
    logic             rd_issue;
    logic [WIDTH-1:0] rdata;

    // enq_ready looks only at committed BRAM entries, never at a same-cycle dequeue.
    assign enq_ready = (cnt_q != CNT_W'(DEPTH)) & ~flush;
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid_q & deq_ready;
    assign rd_issue  = fifo_rd_issue(cnt_q != '0, flush, deq_valid_q, inflight_q, deq_ready);

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        cnt_d       = cnt_q;
        inflight_d  = inflight_q;
        deq_valid_d = deq_valid_q;
        deq_data_d  = deq_data_q;

        if (flush) begin
            // An in-flight return is dropped by clearing inflight; deq_data keeps its value.
            wptr_d      = '0;
            rptr_d      = '0;
            cnt_d       = '0;
            inflight_d  = 1'b0;
            deq_valid_d = 1'b0;
        end else begin
            wptr_d     = wptr_q + PTR_W'(enq_fire);
            rptr_d     = rptr_q + PTR_W'(rd_issue);
            cnt_d      = cnt_q + CNT_W'(enq_fire) - CNT_W'(rd_issue);
            inflight_d = rd_issue;
            if (inflight_q) begin
                deq_valid_d = 1'b1;
                deq_data_d  = rdata;
            end else if (deq_fire) begin
                deq_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            deq_valid_q <= 1'b0;
            deq_data_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            inflight_q  <= inflight_d;
            deq_valid_q <= deq_valid_d;
            deq_data_q  <= deq_data_d;
        end
    end

    assign deq_valid = deq_valid_q;
    assign deq_data  = deq_data_q;
    assign occupancy = OCC_W'(cnt_q) + OCC_W'(deq_valid_q) + OCC_W'(inflight_q);

    // Reads only target committed entries and writes stop at full, so the
    // two ports never address the same entry in the same cycle.
    bram_1rport_1wport #(
        .OUTER_WIDTH (DEPTH),
        .INNER_WIDTH (WIDTH)
    ) u_bram (
        .CLK      (CLK),
        .wen_byte ({BE_W{enq_fire}}),
        .windex   (wptr_q),
        .wdata    (enq_data),
        .ren      (rd_issue),
        .rindex   (rptr_q),
        .rdata    (rdata)
    );

endmodule

// File: tb/tb_bram_1rport_1wport_fifo.sv
// ---------------------------------------------------------------------------
// tb_bram_1rport_1wport_fifo
//   Directed bench for bram_1rport_1wport_fifo (DEPTH=32, WIDTH=32).
//   Inputs change 1 time unit after posedge; outputs are sampled at negedge,
//   so each observation reflects the state held during that cycle.
// ---------------------------------------------------------------------------
module tb_bram_1rport_1wport_fifo;

    localparam int DEPTH = 32;
    localparam int WIDTH = 32;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             flush;
    logic             enq_valid;
    logic [WIDTH-1:0] enq_data;
    logic             enq_ready;
    logic             deq_valid;
    logic [WIDTH-1:0] deq_data;
    logic             deq_ready;
    logic [5:0]       occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    bram_1rport_1wport_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_ready (deq_ready),
        .occupancy (occupancy)
    );

    typedef struct {
        logic        ev;
        logic [31:0] ed;
        logic        dr;
        logic        fl;
        logic        x_dv;
        logic [31:0] x_dd;   // checked only when x_dv
        int          x_occ;
        logic        x_er;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST      = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_data  = '0;
        deq_ready = 1'b0;
        step();
        step();
        nRST = 1'b1;
    endtask

    // Take the head when it appears; a missing head within the bound is a failure.
    task automatic expect_deq(input string name, input logic [31:0] exp, input int bound);
        bit got = 0;
        deq_ready = 1'b1;
        for (int k = 0; k < bound; k++) begin
            @(negedge CLK);
            if (deq_valid) begin
                check(name, deq_data, exp);
                got = 1;
                step();
                break;
            end
            step();
        end
        deq_ready = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout, deq_valid never rose, expected 0x%0h", name, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, rcvd, accepts, first_cyc;
        bit prev_stall;

        //        ev    ed            dr    fl    x_dv  x_dd          occ x_er
        vecs[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 32'h0,          0, 1'b1};
        vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,          1, 1'b1};
        vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,          1, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA5A5_0001,  1, 1'b1};
        vecs[4]  = '{1'b1, 32'hB000_0002, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001,  1, 1'b1};
        vecs[5]  = '{1'b1, 32'hB000_0003, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001,  2, 1'b1};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hA5A5_0001,  3, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,          2, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hB000_0002,  2, 1'b1};
        vecs[9]  = '{1'b1, 32'hC000_0004, 1'b1, 1'b0, 1'b0, 32'h0,          1, 1'b1};
        vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hB000_0003,  2, 1'b1};
        vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hB000_0003,  2, 1'b0};
        vecs[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,          0, 1'b1};
        vecs[13] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0,          0, 1'b1};
        vecs[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,          1, 1'b1};
        vecs[15] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,          1, 1'b1};
        vecs[16] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_1234,  1, 1'b1};
        vecs[17] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,          0, 1'b1};

        // ---- reset state ----
        do_reset();
        @(negedge CLK);
        check("reset.deq_valid", 32'(deq_valid), 32'd0);
        check("reset.deq_data",  deq_data,       32'd0);
        check("reset.occupancy", 32'(occupancy), 32'd0);
        check("reset.enq_ready", 32'(enq_ready), 32'd1);
        step();

        // ---- table: latency, stall/hold, drain, flush, post-flush enq ----
        for (int i = 0; i < 18; i++) begin
            enq_valid = vecs[i].ev;
            enq_data  = vecs[i].ed;
            deq_ready = vecs[i].dr;
            flush     = vecs[i].fl;
            @(negedge CLK);
            check($sformatf("vec%0d.deq_valid", i), 32'(deq_valid), 32'(vecs[i].x_dv));
            if (vecs[i].x_dv)
                check($sformatf("vec%0d.deq_data", i), deq_data, vecs[i].x_dd);
            check($sformatf("vec%0d.occupancy", i), 32'(occupancy), 32'(vecs[i].x_occ));
            check($sformatf("vec%0d.enq_ready", i), 32'(enq_ready), 32'(vecs[i].x_er));
            step();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        flush     = 1'b0;

        // ---- back-to-back stream 0..63 with deq_ready=1 ----
        do_reset();
        sent = 0; rcvd = 0; first_cyc = -1;
        for (int c = 0; c < 400 && rcvd < 64; c++) begin
            enq_valid = (sent < 64);
            enq_data  = 32'(sent);
            deq_ready = 1'b1;
            @(negedge CLK);
            if (enq_valid && enq_ready) sent++;
            if (deq_valid) begin
                if (first_cyc < 0) first_cyc = c;
                check($sformatf("b2b.data%0d", rcvd), deq_data, 32'(rcvd));
                rcvd++;
            end
            step();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("b2b.first_valid_cycle", 32'(first_cyc), 32'd3);
        check("b2b.count", 32'(rcvd), 32'd64);

        // ---- fill to DEPTH+1, reopen after one deq, drain in order ----
        do_reset();
        accepts = 0;
        for (int c = 0; c < 40; c++) begin
            enq_valid = 1'b1;
            enq_data  = 32'(100 + accepts);
            @(negedge CLK);
            if (enq_ready) accepts++;
            step();
        end
        enq_valid = 1'b0;
        @(negedge CLK);
        check("full.accepts",   32'(accepts),   32'd33);
        check("full.occupancy", 32'(occupancy), 32'd33);
        check("full.enq_ready", 32'(enq_ready), 32'd0);
        check("full.head",      deq_data,       32'd100);
        step();
        deq_ready = 1'b1;
        @(negedge CLK);
        check("full.deq_cycle_enq_ready", 32'(enq_ready), 32'd0);
        step();
        deq_ready = 1'b0;
        @(negedge CLK);
        check("full.reopen_enq_ready", 32'(enq_ready), 32'd1);
        check("full.reopen_occupancy", 32'(occupancy), 32'd32);
        step();
        for (int j = 1; j <= 32; j++)
            expect_deq($sformatf("full.drain%0d", j), 32'(100 + j), 10);
        @(negedge CLK);
        check("full.empty_occupancy", 32'(occupancy), 32'd0);
        step();

        // ---- wrap: 100 entries with random enq gaps and deq stalls ----
        do_reset();
        sent = 0; rcvd = 0; prev_stall = 0;
        for (int c = 0; c < 3000 && rcvd < 100; c++) begin
            enq_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
            enq_data  = 32'h7000_0000 + 32'(sent);
            deq_ready = ($urandom_range(0, 2) != 0);
            @(negedge CLK);
            if (prev_stall) check("wrap.hold_valid", 32'(deq_valid), 32'd1);
            if (enq_valid && enq_ready) sent++;
            if (deq_valid) begin
                check($sformatf("wrap.head%0d", rcvd), deq_data, 32'h7000_0000 + 32'(rcvd));
                if (deq_ready) rcvd++;
            end
            prev_stall = deq_valid && !deq_ready;
            step();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("wrap.count", 32'(rcvd), 32'd100);

        // ---- flush the cycle after a read issue, 5 entries queued ----
        do_reset();
        for (int j = 0; j < 5; j++) begin
            enq_valid = 1'b1;
            enq_data  = 32'(11 + j);
            step();
        end
        enq_valid = 1'b0;
        step(); step(); step();
        @(negedge CLK);
        check("flush.pre_occupancy", 32'(occupancy), 32'd5);
        check("flush.pre_head",      deq_data,       32'd11);
        step();
        deq_ready = 1'b1;          // deq fire + read issue
        step();
        deq_ready = 1'b0;
        flush     = 1'b1;          // read is in flight now
        @(negedge CLK);
        check("flush.enq_ready_during", 32'(enq_ready), 32'd0);
        step();
        flush = 1'b0;
        @(negedge CLK);
        check("flush.deq_valid",  32'(deq_valid), 32'd0);
        check("flush.occupancy",  32'(occupancy), 32'd0);
        step();
        @(negedge CLK);
        check("flush.no_capture", 32'(deq_valid), 32'd0);
        step();
        enq_valid = 1'b1;
        enq_data  = 32'h0000_1234;
        step();
        enq_valid = 1'b0;
        expect_deq("flush.first_after", 32'h0000_1234, 10);

        // ---- nRST mid-stream ----
        for (int j = 0; j < 6; j++) begin
            enq_valid = 1'b1;
            enq_data  = 32'hDEAD_0000 + 32'(j);
            step();
        end
        enq_valid = 1'b1;
        deq_ready = 1'b1;
        nRST      = 1'b0;
        step();
        nRST      = 1'b1;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        @(negedge CLK);
        check("rst_mid.deq_valid", 32'(deq_valid), 32'd0);
        check("rst_mid.deq_data",  deq_data,       32'd0);
        check("rst_mid.occupancy", 32'(occupancy), 32'd0);
        check("rst_mid.enq_ready", 32'(enq_ready), 32'd1);
        step();
        for (int j = 0; j < 4; j++) begin
            @(negedge CLK);
            check($sformatf("rst_mid.idle%0d", j), 32'(deq_valid), 32'd0);
            step();
        end
        enq_valid = 1'b1;
        enq_data  = 32'h0000_55AA;
        step();
        enq_valid = 1'b0;
        expect_deq("rst_mid.first_after", 32'h0000_55AA, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
